dac_playback_ctrl: RTL

Parametrised successor to the single-channel DAC playback controller. Sits between the waveform FIFO (AXI-Stream slave) and one RFSoC data converter DAC stream (AXI-Stream master). Supports arm-then-trigger playback, a programmable start delay, a programmable beat count and repeat count, and per-sample start/end masks. Configuration arrives on parallel ports driven by the upstream config block; it is latched at trigger.

---
 rtl/dac_playback_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dac_playback_ctrl.sv
// DAC playback controller: arm/trigger bursts from the waveform FIFO to one DAC AXIS stream.
// Optional build macro DAC_PLAYBACK_AUTO_REARM_EN: return to ARMED after each burst instead of IDLE.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for trigger_in, cfg latched on trigger
// DELAY   | counting programmed start delay
// RUN     | one beat per cycle from FIFO to DAC
// CLEANUP | last beat on output, done pulse
module dac_playback_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int SPB      = 16,
    parameter int CNT_W    = 32,
    parameter int DLY_W    = 16,
    parameter int REP_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        cfg_beats,
    input  logic [DLY_W-1:0]        cfg_delay,
    input  logic [REP_W-1:0]        cfg_repeats,
    input  logic [SPB-1:0]          cfg_start_mask,
    input  logic [SPB-1:0]          cfg_end_mask,
    input  logic                    arm,
    input  logic                    trigger_in,
    input  logic                    abort,
    input  logic [SAMPLE_W*SPB-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [SAMPLE_W*SPB-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    localparam int DW = SAMPLE_W * SPB;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_RUN     = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [DLY_W-1:0] dly_cnt;
    logic [SPB-1:0]   start_mask_q;
    logic [SPB-1:0]   end_mask_q;
    logic             first_q;
    logic             underrun_q;
    logic [DW-1:0]    tdata_q;
    logic [SPB-1:0]   sample_en;
    logic [DW-1:0]    beat_masked;
    logic             trig_go;
    logic             pass_end;
    logic             last_beat;
    logic             unused_tready;

    // The DAC consumes every cycle, so backpressure is never honoured.
    assign unused_tready = m_axis_tready;

    assign trig_go   = (state == S_ARMED) && trigger_in && !abort;
    assign pass_end  = (beat_cnt == CNT_W'(1));
    assign last_beat = pass_end && (rep_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm) state_nxt = S_ARMED;
            S_ARMED: begin
                if (trigger_in) begin
                    if (cfg_beats == '0)      state_nxt = S_CLEANUP;
                    else if (cfg_delay == '0) state_nxt = S_RUN;
                    else                      state_nxt = S_DELAY;
                end
            end
            S_DELAY:   if (dly_cnt == DLY_W'(1)) state_nxt = S_RUN;
            S_RUN:     if (last_beat) state_nxt = S_CLEANUP;
`ifdef DAC_PLAYBACK_AUTO_REARM_EN
            S_CLEANUP: state_nxt = S_ARMED;
`else
            S_CLEANUP: state_nxt = S_IDLE;
`endif
            default:   state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        s_axis_tready = (state == S_RUN);
        busy          = (state == S_DELAY) || (state == S_RUN) || (state == S_CLEANUP);
        done          = (state == S_CLEANUP);
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = tdata_q;
        underrun      = underrun_q;
    end

    // Down-counters: beat_cnt terminates at 1 per pass, rep_cnt counts remaining passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q      <= '0;
            beat_cnt     <= '0;
            rep_cnt      <= '0;
            dly_cnt      <= '0;
            start_mask_q <= '0;
            end_mask_q   <= '0;
            first_q      <= 1'b0;
        end else if (trig_go) begin
            beats_q      <= cfg_beats;
            beat_cnt     <= cfg_beats;
            rep_cnt      <= cfg_repeats;
            dly_cnt      <= cfg_delay;
            start_mask_q <= cfg_start_mask;
            end_mask_q   <= cfg_end_mask;
            first_q      <= 1'b1;
        end else if (state == S_DELAY) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
        end else if (state == S_RUN) begin
            first_q <= 1'b0;
            if (pass_end) begin
                if (rep_cnt != '0) begin
                    rep_cnt  <= rep_cnt - REP_W'(1);
                    beat_cnt <= beats_q;
                end else begin
                    beat_cnt <= '0;
                end
            end else begin
                beat_cnt <= beat_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (trig_go) begin
            underrun_q <= 1'b0;
        end else if ((state == S_RUN) && !s_axis_tvalid && !abort) begin
            underrun_q <= 1'b1;
        end
    end

    always_comb begin
        sample_en = {SPB{1'b1}};
        if (first_q)   sample_en = sample_en & start_mask_q;
        if (last_beat) sample_en = sample_en & end_mask_q;
        beat_masked = '0;
        for (int i = 0; i < SPB; i++) begin
            if (sample_en[i]) beat_masked[i*SAMPLE_W +: SAMPLE_W] = s_axis_tdata[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Missing FIFO data or an aborted beat goes out as silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q <= '0;
        end else if ((state == S_RUN) && s_axis_tvalid && !abort) begin
            tdata_q <= beat_masked;
        end else begin
            tdata_q <= '0;
        end
    end

endmodule
